// File: rtl/mem_writeback_stage.sv
// mem_writeback_stage: RV32I memory/writeback stage issuing data-memory requests and driving the register-file write port.
// Ports: clk/reset (async, active-low); s2_* execute-stage handoff with s2_ready backpressure;
// dcache_req_* valid/ready request channel (word address, byte mask, lane-shifted data);
// dcache_resp_valid/dcache_dout load response; s3_* registered register-file write and misaligned pulse.
module mem_writeback_stage #(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s2_valid,
  output logic                 s2_ready,
  input  logic [DATA_BITS-1:0] s2_alu_out,
  input  logic [DATA_BITS-1:0] s2_rs2_data_out,
  input  logic [6:0]           s2_opcode,
  input  logic [2:0]           s2_func,
  input  logic [4:0]           s2_rd,
  output logic                 dcache_req_valid,
  input  logic                 dcache_req_ready,
  output logic [ADDR_BITS-1:0] dcache_addr,
  output logic [3:0]           dcache_we,
  output logic [DATA_BITS-1:0] dcache_din,
  input  logic                 dcache_resp_valid,
  input  logic [DATA_BITS-1:0] dcache_dout,
  output logic                 s3_rf_we,
  output logic [4:0]           s3_rd,
  output logic [DATA_BITS-1:0] s3_wb_data,
  output logic                 s3_misaligned
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  logic [1:0]           st;
  logic [ADDR_BITS-1:0] addr_q;
  logic [2:0]           func_q;
  logic [4:0]           rd_q;
  logic                 load_q;
  logic                 accept, is_load, is_mem, wb_op, byte_op, half_op, mis, resp_fire;
  logic [1:0]           a;
  logic [3:0]           mask;
  logic [DATA_BITS-1:0] ld, ld_ext;
  always_comb begin
    a = s2_alu_out[1:0];
    is_load = s2_opcode == OP_LOAD;
    is_mem = is_load | (s2_opcode == OP_STORE);
    wb_op = (s2_opcode == OP_OP) | (s2_opcode == OP_IMM) | (s2_opcode == OP_LUI) |
            (s2_opcode == OP_AUIPC) | (s2_opcode == OP_JAL) | (s2_opcode == OP_JALR);
    byte_op = s2_func[1:0] == 2'b00;
    half_op = s2_func[1:0] == 2'b01;
    // undefined widths behave as word accesses, including the alignment check
    mis = is_mem & ((half_op & a[0]) | (!byte_op & !half_op & |a));
    mask = byte_op ? 4'b0001 << a : half_op ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
    accept = s2_valid & s2_ready;
    resp_fire = (st == RESP) & dcache_resp_valid;
    ld = dcache_dout >> {addr_q[1:0], 3'b000};
    ld_ext = func_q[1:0] == 2'b00 ? {{(DATA_BITS-8){~func_q[2] & ld[7]}}, ld[7:0]} :
             func_q[1:0] == 2'b01 ? {{(DATA_BITS-16){~func_q[2] & ld[15]}}, ld[15:0]} : ld;
  end
  assign s2_ready = st == IDLE;
  assign dcache_req_valid = st == REQ;
  assign dcache_addr = {addr_q[ADDR_BITS-1:2], 2'b00};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= IDLE;
      addr_q <= '0;
      func_q <= '0;
      rd_q <= '0;
      load_q <= 1'b0;
      dcache_we <= '0;
      dcache_din <= '0;
      s3_rf_we <= 1'b0;
      s3_rd <= '0;
      s3_wb_data <= '0;
      s3_misaligned <= 1'b0;
    end else begin
      s3_rf_we <= (accept & wb_op & |s2_rd) | (resp_fire & |rd_q);
      s3_misaligned <= accept & mis;
      if (accept & wb_op & |s2_rd) begin
        s3_rd <= s2_rd;
        s3_wb_data <= s2_alu_out;
      end else if (resp_fire & |rd_q) begin
        s3_rd <= rd_q;
        s3_wb_data <= ld_ext;
      end
      if (accept & is_mem & !mis) begin
        st <= REQ;
        addr_q <= s2_alu_out[ADDR_BITS-1:0];
        func_q <= s2_func;
        rd_q <= s2_rd;
        load_q <= is_load;
        dcache_we <= is_load ? 4'b0000 : mask;
        dcache_din <= s2_rs2_data_out << {a, 3'b000};
      end else if (st == REQ && dcache_req_ready) st <= load_q ? RESP : IDLE;
      else if (resp_fire) st <= IDLE;
    end
  end
endmodule

// File: doc/mem_writeback_stage.md
Name: mem_writeback_stage

Overview:
Stage #3 of the 3-stage RV32I pipeline; consumes the execute-stage results (ALU result, store data, opcode/func, rd).
- Issues data-memory requests over a valid/ready request channel and a valid-only response channel.
- Aligns and sign/zero-extends load data; stores need no further stage.
- Produces the register-file write port, and stalls execute via s2_ready while a memory access is outstanding.

Parameters:
DATA_BITS, 32, datapath width (equals CPU_DATA_BITS)
ADDR_BITS, 32, data-memory byte address width (equals CPU_ADDR_BITS)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
s2_valid  input  1  execute stage holds a valid instruction
s2_ready  output  1  this stage accepts the instruction this cycle
s2_alu_out  input  DATA_BITS  ALU result / effective address / link value
s2_rs2_data_out  input  DATA_BITS  store data
s2_opcode  input  7  instruction opcode (Opcode.vh encodings)
s2_func  input  3  funct3
s2_rd  input  5  destination register
dcache_req_valid  output  1  memory request valid
dcache_req_ready  input  1  memory accepts request
dcache_addr  output  ADDR_BITS  word-aligned address {addr[ADDR_BITS-1:2],2'b00}
dcache_we  output  4  byte write mask; 0 = read
dcache_din  output  DATA_BITS  lane-shifted store data
dcache_resp_valid  input  1  load data valid
dcache_dout  input  DATA_BITS  load word
s3_rf_we  output  1  register-file write enable
s3_rd  output  5  write register
s3_wb_data  output  DATA_BITS  write data
s3_misaligned  output  1  one-cycle pulse: access suppressed, misaligned

Behaviour:
- Reset (reset==0, async): state IDLE; every output 0 except s2_ready, which is 1. Requests drop immediately. No response is pending after reset; a stale dcache_resp_valid in IDLE is ignored.
- FSM states: IDLE, REQ, RESP.
- s2_ready = (state==IDLE). Accept = s2_valid & s2_ready. On accept, opcode, func, rd, addr, and store data are registered.
- Non-memory opcode (OP, OP_IMM, LUI, AUIPC, JAL, JALR) accepted in cycle N:
  - s3_rf_we=1 in cycle N+1 with s3_wb_data=s2_alu_out and s3_rd=s2_rd.
  - State stays IDLE, so throughput is 1 per cycle.
- BRANCH, or any unknown opcode: consumed, no write. It is a bubble.
- rd==0: s3_rf_we is never asserted, for any opcode.
- STORE accepted in cycle N:
  - State is REQ from N+1; dcache_req_valid=1 with registered address.
  - Byte mask: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111.
  - dcache_din = rs2 shifted left by 8*addr[1:0].
  - All request outputs are held stable until dcache_req_ready. Ready sampled in cycle M → IDLE at M+1, dcache_req_valid=0 at M+1.
- LOAD accepted in cycle N:
  - REQ with we=4'b0000, same handshake. After the handshake, state is RESP.
  - dcache_resp_valid is honoured only in RESP; the earliest response is the cycle after acceptance.
  - Response in cycle R → s3_rf_we=1 at R+1, state IDLE at R+1.
  - Data = dcache_dout >> 8*addr[1:0], then extended per funct3: LB 000 sign-8, LH 001 sign-16, LW 010 full, LBU 100 zero-8, LHU 101 zero-16. Other funct3 values load as LW.
- Misaligned access: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - No request is issued and no write occurs.
  - s3_misaligned pulses in cycle N+1; state stays IDLE.
- s3_rf_we, s3_rd, s3_wb_data and s3_misaligned are registered. s3_rf_we is a single-cycle pulse per instruction; s3_rd and s3_wb_data hold their last value when it is low.
- dcache_req_valid never depends combinationally on dcache_req_ready.

Test Plan:
- ALU stream: reset released, then OP_IMM rd=5 alu_out=0x1234 followed back-to-back by OP rd=6 alu_out=0xFFFF0000 → s2_ready stays 1; rf_we pulses on consecutive cycles, rd=5 data 0x1234, then rd=6 data 0xFFFF0000. Repeat with rd=0 → no rf_we.
- Store lanes: SB addr 0x103 rs2=0xAB with req_ready delayed 3 cycles → addr 0x100, we=4'b1000, din[31:24]=0xAB. req_valid and outputs stable all 3 cycles; s2_ready=0 until the cycle after ready.
- Loads: word 0x80F0_7F01 at 0x200. LB@0x201 → 0x0000007F; LB@0x203 → 0xFFFFFF80; LHU@0x202 → 0x000080F0; LH@0x202 → 0xFFFF80F0. rf_we exactly 1 cycle after resp_valid.
- Misaligned: LW@0x202 and SH@0x101 → no dcache_req_valid, s3_misaligned pulse, no rf_we, next instruction accepted the following cycle.
- Reset mid-op: LOAD in RESP, reset asserted asynchronously between edges → all outputs 0 immediately and s2_ready=1. resp_valid driven the cycle after release → no rf_we.
- Handshake corner: req_ready held high continuously with resp_valid spuriously high in IDLE/REQ → responses ignored until RESP. A load/store pair completes in order with correct data.
